mic_frame_sequencer: RTL and testbench
======================================

# mic_frame_sequencer

Readout scheduler between the per-microphone sample FIFOs and the SPI slave. On each SPI transaction it walks the NUM_MICS FIFOs round-robin. Each SPI word request causes one FIFO pop, or a fill word if that FIFO is empty. The result is presented as the next word to shift out, with fixed latency, underrun accounting and abort on slave-select release. It replaces ad-hoc read sequencing in the top level with one sequenced, verifiable controller.

## Interface
Parameters:
- NUM_MICS, 9, number of FIFOs/mics sequenced (2..31)
- DATA_WIDTH, 16, FIFO word and SPI word width
- FILL_WORD, 16'h0007, word sent when the addressed FIFO is empty

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ssel  in  1  raw SPI slave select, active low, asynchronous to clk
- data_needed  in  1  raw SPI-slave "next word" strobe; the rising edge is the request
- fifo_rdempty  in  NUM_MICS  per-FIFO empty flags
- fifo_q  in  NUM_MICS*DATA_WIDTH  flattened FIFO outputs; mic i at [i*DATA_WIDTH +: DATA_WIDTH]; valid 1 clk after rdreq
- fifo_rdreq  out  NUM_MICS  one-hot pop strobe, at most one bit high per cycle
- fifo_rdclk_en  out  1  one-cycle pulse when the mic index wraps to 0
- tx_data  out  DATA_WIDTH  word to load into the SPI shift register
- tx_valid  out  1  one-cycle pulse when tx_data updates
- mic_idx  out  5  mic index that the next request will address
- busy  out  1  high while in READ or CAPTURE
- frame_count  out  16  completed frames, wraps
- underrun_count  out  16  fill words issued, saturates at 16'hFFFF
- overrun_err  out  1  sticky; a request arrived while busy

## Operation
- ssel and data_needed each pass through a 2-FF synchronizer, then a registered edge detect. sel_fall, sel_rise and req_rise are single-cycle internal pulses.
- States: IDLE, ARMED, READ, CAPTURE.
- IDLE:
  - sel_fall sets mic_idx=0, clears overrun_err, and moves to ARMED.
  - Requests in IDLE are ignored.
- ARMED:
  - req_rise moves to READ.
  - sel_rise moves to IDLE.
- READ, one cycle:
  - If fifo_rdempty[mic_idx]=0, drive fifo_rdreq[mic_idx]=1 and record was_empty=0.
  - Otherwise no pop, and record was_empty=1.
  - Then go to CAPTURE.
- CAPTURE, one cycle:
  - tx_data <= was_empty ? FILL_WORD : fifo_q slice[mic_idx]; pulse tx_valid.
  - If was_empty, increment underrun_count (saturating).
  - mic_idx increments. At mic_idx==NUM_MICS-1 it wraps to 0, pulses fifo_rdclk_en and increments frame_count.
  - Return to ARMED.
- req_rise in READ or CAPTURE is dropped and sets overrun_err.
- sel_rise in ARMED, READ or CAPTURE is a priority abort to IDLE. fifo_rdreq is forced low that cycle. A pending capture is discarded: no tx_valid, no counter update.
- sel_rise wins over a same-cycle req_rise.
- sel_fall while not IDLE is ignored.
- Counters persist across frames and clear only on rst.

## Timing
- Reset values: fifo_rdreq=0, fifo_rdclk_en=0, tx_data=FILL_WORD, tx_valid=0, mic_idx=0, busy=0, frame_count=0, underrun_count=0, overrun_err=0, state=IDLE. Synchronizer flops reset to ssel=1, data_needed=0.
- Latency, raw data_needed rise to tx_valid: 3 cycles synchronizer/edge detect, +1 READ, +1 CAPTURE = 5 clk. This is fixed regardless of empty/non-empty.
- Minimum request spacing is 3 clk, measured as req_rise to the next accepted req_rise.
- rst asserted mid-operation returns every output to its reset value the next cycle. Any in-flight pop is abandoned.

## Configuration
- MIC_SEQ_HEADER_EN defined:
  - The first request of each frame (mic_idx==0, header not yet sent) returns {8'hA5, frame_count[7:0]} as the header.
  - The header request does not pop a FIFO or advance mic_idx.
  - Latency is the same as a data word.
  - A frame is NUM_MICS+1 words.
  - The header flag re-arms on wrap and on sel_fall.
- Not defined: no header; a frame is exactly NUM_MICS words.

## Test plan
- Reset, then idle 10 clk -> tx_data=16'h0007, all counters 0, fifo_rdreq=0.
- All FIFOs non-empty with fifo_q slice i = 16'h0100+i; ssel low; 9 requests ->
  - tx_data sequence 0100..0108;
  - each fifo_rdreq bit pulses exactly once;
  - fifo_rdclk_en pulses once;
  - frame_count=1;
  - each tx_valid is 5 clk after its raw request edge.
- FIFO 3 empty, others full; 9 requests -> word 3 = 16'h0007, fifo_rdreq[3] never high, underrun_count=1.
- Second request raised 1 clk after the first is accepted -> overrun_err=1, only one tx_valid. The next sel_fall clears overrun_err.
- ssel rises 1 clk after a req_rise -> no tx_valid, fifo_rdreq low, state IDLE, mic_idx unchanged.
- With MIC_SEQ_HEADER_EN and frame_count=5 -> first word 16'hA505, then mic words 0..8.

Source files
------------

// File: rtl/mic_frame_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mic_frame_sequencer_if : SPI-side strobes, FIFO read port and status bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface mic_frame_sequencer_if #(
  parameter int NUM_MICS   = 9,
  parameter int DATA_WIDTH = 16
);
  logic                           ssel;
  logic                           data_needed;
  logic [NUM_MICS-1:0]            fifo_rdempty;
  logic [NUM_MICS*DATA_WIDTH-1:0] fifo_q;
  logic [NUM_MICS-1:0]            fifo_rdreq;
  logic                           fifo_rdclk_en;
  logic [DATA_WIDTH-1:0]          tx_data;
  logic                           tx_valid;
  logic [4:0]                     mic_idx;
  logic                           busy;
  logic [15:0]                    frame_count;
  logic [15:0]                    underrun_count;
  logic                           overrun_err;

  // master: the sequencer; slave: the SPI slave / FIFO bank around it
  modport master (
    input  ssel, data_needed, fifo_rdempty, fifo_q,
    output fifo_rdreq, fifo_rdclk_en, tx_data, tx_valid, mic_idx, busy,
           frame_count, underrun_count, overrun_err
  );

  modport slave (
    output ssel, data_needed, fifo_rdempty, fifo_q,
    input  fifo_rdreq, fifo_rdclk_en, tx_data, tx_valid, mic_idx, busy,
           frame_count, underrun_count, overrun_err
  );
endinterface
`default_nettype wire

// File: rtl/mic_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mic_frame_sequencer : round-robin FIFO readout scheduler feeding the SPI slave
// Optional frame header word enabled by defining MIC_SEQ_HEADER_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mic_frame_sequencer #(
  parameter int                    NUM_MICS   = 9,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(16'h0007)
) (
  input  logic                 clk,
  input  logic                 rst,
  mic_frame_sequencer_if.master bus
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MICS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic r_ssel_meta, r_ssel_sync, r_ssel_prev;
  logic r_req_meta, r_req_sync, r_req_prev;
  logic w_sel_fall, w_sel_rise, w_req_rise;

  logic                  w_arm, w_read, w_commit, w_overrun, w_wrap, w_hdr_now;
  logic                  w_sel_empty;
  logic [DATA_WIDTH-1:0] w_sel_q, w_header;
  logic [NUM_MICS-1:0]   w_rdreq;

  logic                  r_was_empty, r_is_header;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid, r_rdclk_en, r_overrun;
  logic [4:0]            r_mic_idx;
  logic [15:0]           r_frame_count, r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_ssel_meta, r_ssel_sync, r_ssel_prev} <= 3'b111;
      {r_req_meta, r_req_sync, r_req_prev}    <= 3'b000;
    end else begin
      r_ssel_meta <= bus.ssel;
      r_ssel_sync <= r_ssel_meta;
      r_ssel_prev <= r_ssel_sync;
      r_req_meta  <= bus.data_needed;
      r_req_sync  <= r_req_meta;
      r_req_prev  <= r_req_sync;
    end
  end

  assign w_sel_fall = r_ssel_prev & ~r_ssel_sync;
  assign w_sel_rise = ~r_ssel_prev & r_ssel_sync;
  assign w_req_rise = r_req_sync & ~r_req_prev;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // sel_rise aborts every active state and outranks a same-cycle request
  always_comb begin
    w_next    = r_state;
    w_arm     = 1'b0;
    w_read    = 1'b0;
    w_commit  = 1'b0;
    w_overrun = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_fall) begin
          w_next = ARMED;
          w_arm  = 1'b1;
        end
      end
      ARMED: begin
        if (w_sel_rise)      w_next = IDLE;
        else if (w_req_rise) w_next = READ;
      end
      READ: begin
        if (w_sel_rise) begin
          w_next = IDLE;
        end else begin
          w_next    = CAPTURE;
          w_read    = 1'b1;
          w_overrun = w_req_rise;
        end
      end
      CAPTURE: begin
        w_next = w_sel_rise ? IDLE : ARMED;
        if (!w_sel_rise) begin
          w_commit  = 1'b1;
          w_overrun = w_req_rise;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sel_empty = 1'b1;
    w_sel_q     = '0;
    w_rdreq     = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      if (r_mic_idx == 5'(i)) begin
        w_sel_empty = bus.fifo_rdempty[i];
        w_sel_q     = bus.fifo_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
      w_rdreq[i] = w_read & ~w_hdr_now & ~rst & ~bus.fifo_rdempty[i] &
                   (r_mic_idx == 5'(i));
    end
  end

  assign w_header = DATA_WIDTH'({8'hA5, r_frame_count[7:0]});
  assign w_wrap   = w_commit & ~r_is_header & (r_mic_idx == LAST_IDX);

`ifdef MIC_SEQ_HEADER_EN
  logic r_hdr_pending;

  always_ff @(posedge clk) begin
    if (rst)                         r_hdr_pending <= 1'b1;
    else if (w_arm || w_wrap)        r_hdr_pending <= 1'b1;
    else if (w_commit && r_is_header) r_hdr_pending <= 1'b0;
  end

  assign w_hdr_now = r_hdr_pending;
`else
  assign w_hdr_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_was_empty   <= 1'b0;
      r_is_header   <= 1'b0;
      r_tx_data     <= FILL_WORD;
      r_tx_valid    <= 1'b0;
      r_rdclk_en    <= 1'b0;
      r_overrun     <= 1'b0;
      r_mic_idx     <= '0;
      r_frame_count <= '0;
      r_underrun    <= '0;
    end else begin
      r_tx_valid <= 1'b0;
      r_rdclk_en <= 1'b0;
      if (w_arm) begin
        r_mic_idx <= '0;
        r_overrun <= 1'b0;
      end else if (w_overrun) begin
        r_overrun <= 1'b1;
      end
      if (w_read) begin
        r_was_empty <= w_sel_empty;
        r_is_header <= w_hdr_now;
      end
      if (w_commit) begin
        r_tx_valid <= 1'b1;
        if (r_is_header) begin
          r_tx_data <= w_header;
        end else begin
          r_tx_data <= r_was_empty ? FILL_WORD : w_sel_q;
          if (r_was_empty && (r_underrun != 16'hFFFF))
            r_underrun <= r_underrun + 16'd1;
          if (w_wrap) begin
            r_mic_idx     <= '0;
            r_rdclk_en    <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end else begin
            r_mic_idx <= r_mic_idx + 5'd1;
          end
        end
      end
    end
  end

  assign bus.fifo_rdreq     = w_rdreq;
  assign bus.fifo_rdclk_en  = r_rdclk_en;
  assign bus.tx_data        = r_tx_data;
  assign bus.tx_valid       = r_tx_valid;
  assign bus.mic_idx        = r_mic_idx;
  assign bus.busy           = (r_state == READ) || (r_state == CAPTURE);
  assign bus.frame_count    = r_frame_count;
  assign bus.underrun_count = r_underrun;
  assign bus.overrun_err    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mic_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mic_frame_sequencer : randomized bench with a transaction-level reference
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mic_frame_sequencer;
  localparam int          NUM_MICS = 9;
  localparam int          DW       = 16;
  localparam logic [15:0] FILL     = 16'h0007;
`ifdef MIC_SEQ_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mic_frame_sequencer_if #(.NUM_MICS(NUM_MICS), .DATA_WIDTH(DW)) bus();

  mic_frame_sequencer #(
    .NUM_MICS(NUM_MICS), .DATA_WIDTH(DW), .FILL_WORD(FILL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // FIFO bank environment: pops on rdreq, output valid the cycle after
  logic [15:0]         fq[NUM_MICS][$];
  logic [15:0]         q_reg[NUM_MICS] = '{default: 16'h0};
  logic [NUM_MICS-1:0] rd_latched = '0;

  always @(negedge clk) rd_latched = bus.fifo_rdreq;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_MICS; i++) begin
      if (rd_latched[i] && fq[i].size() > 0) q_reg[i] = fq[i].pop_front();
      bus.fifo_rdempty[i] <= (fq[i].size() == 0);
    end
  end

  for (genvar g = 0; g < NUM_MICS; g++) begin : g_fifo_q
    assign bus.fifo_q[g*DW +: DW] = q_reg[g];
  end

  // Transaction-level model: one entry per accepted word request
  typedef struct {
    int                  due;
    int                  rd_cyc;
    logic [NUM_MICS-1:0] rd_mask;
    logic [15:0]         word;
    bit                  wrap;
    bit                  popped;
    int                  idx_b, fc_b, ur_b;
    bit                  hdr_b;
  } exp_t;

  exp_t        eq[$];
  logic [15:0] mq[NUM_MICS][$];
  bit          m_armed = 0, m_ovr = 0, m_hdr = 0;
  int          m_idx = 0, m_fc = 0, m_ur = 0, last_r = -100;
  int          n_valid = 0, n_wrap = 0;
  logic [15:0] words[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic model_req(input int n);
    exp_t e;
    int   r = n + 2;
    if (!m_armed) return;
    if (r < last_r + 3) begin
      m_ovr = 1;
      return;
    end
    last_r   = r;
    e.due    = n + 5;
    e.rd_cyc = n + 3;
    e.rd_mask = '0;
    e.wrap   = 0;
    e.popped = 0;
    e.idx_b  = m_idx;
    e.fc_b   = m_fc;
    e.ur_b   = m_ur;
    e.hdr_b  = m_hdr;
    if (m_hdr) begin
      e.word = {8'hA5, 8'(m_fc)};
      m_hdr  = 0;
    end else begin
      if (mq[m_idx].size() > 0) begin
        e.word    = mq[m_idx].pop_front();
        e.rd_mask = NUM_MICS'(1) << m_idx;
        e.popped  = 1;
      end else begin
        e.word = FILL;
        if (m_ur < 65535) m_ur++;
      end
      if (m_idx == NUM_MICS - 1) begin
        m_idx  = 0;
        m_fc   = (m_fc + 1) % 65536;
        e.wrap = 1;
        m_hdr  = (HDR != 0);
      end else begin
        m_idx++;
      end
    end
    eq.push_back(e);
  endtask

  task automatic model_sel_rise(input int s);
    int p = s + 2;
    if (eq.size() > 0) begin
      exp_t e = eq[$];
      if (e.rd_cyc == p || e.rd_cyc + 1 == p) begin
        m_idx = e.idx_b;
        m_fc  = e.fc_b;
        m_ur  = e.ur_b;
        m_hdr = e.hdr_b;
        if (e.rd_cyc == p && e.popped) mq[e.idx_b].push_front(e.word);
        eq.delete(eq.size() - 1);
      end
    end
    m_armed = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic [NUM_MICS-1:0] erd;
      logic                ev, ew;
      logic [15:0]         ed;
      erd = '0; ev = 0; ew = 0; ed = FILL;
      foreach (eq[k]) begin
        if (eq[k].rd_cyc == cyc) erd |= eq[k].rd_mask;
        if (eq[k].due == cyc) begin
          ev = 1; ed = eq[k].word; ew = eq[k].wrap;
        end
      end
      chk("tx_valid", 32'(bus.tx_valid), 32'(ev));
      if (ev) chk("tx_data", 32'(bus.tx_data), 32'(ed));
      chk("fifo_rdreq", 32'(bus.fifo_rdreq), 32'(erd));
      chk("fifo_rdclk_en", 32'(bus.fifo_rdclk_en), 32'(ew));
      if (bus.tx_valid) begin
        n_valid++;
        words.push_back(bus.tx_data);
      end
      if (bus.fifo_rdclk_en) n_wrap++;
      while (eq.size() > 0 && eq[0].due <= cyc) eq.delete(0);
    end
  end

  task automatic issue_req(input int gap);
    @(posedge clk); #1;
    bus.data_needed = 1'b1;
    model_req(cyc);
    @(posedge clk); #1;
    bus.data_needed = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

  task automatic sel_fall();
    @(posedge clk); #1;
    bus.ssel = 1'b0;
    m_armed = 1; m_idx = 0; m_ovr = 0; m_hdr = (HDR != 0); last_r = -100;
    repeat (4) @(posedge clk);
  endtask

  task automatic sel_release();
    @(posedge clk); #1;
    bus.ssel = 1'b1;
    model_sel_rise(cyc);
    repeat (4) @(posedge clk);
  endtask

  task automatic load_fifos(input int mode);
    for (int i = 0; i < NUM_MICS; i++) begin
      fq[i].delete();
      mq[i].delete();
      if (mode == 0) begin
        fq[i].push_back(16'h0100 + 16'(i));
      end else if (mode == 1) begin
        if (i != 3) fq[i].push_back(16'h0200 + 16'(i));
      end else begin
        int n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) fq[i].push_back(16'($urandom));
      end
      foreach (fq[i][k]) mq[i].push_back(fq[i][k]);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_static();
    @(negedge clk);
    chk("mic_idx", 32'(bus.mic_idx), 32'(m_idx));
    chk("frame_count", 32'(bus.frame_count), 32'(m_fc));
    chk("underrun_count", 32'(bus.underrun_count), 32'(m_ur));
    chk("overrun_err", 32'(bus.overrun_err), 32'(m_ovr));
    chk("busy", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int base, nv0, nw0;
    bus.ssel        = 1'b1;
    bus.data_needed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    check_static();
    chk("reset tx_data", 32'(bus.tx_data), 32'h0007);

    // one full frame, all FIFOs loaded
    load_fifos(0);
    sel_fall();
    base = words.size(); nv0 = n_valid; nw0 = n_wrap;
    for (int i = 0; i < NUM_MICS + HDR; i++) issue_req(4);
    repeat (8) @(posedge clk);
    check_static();
    chk("frame1 words", 32'(n_valid - nv0), 32'(NUM_MICS + HDR));
    chk("frame1 wraps", 32'(n_wrap - nw0), 32'd1);
    chk("frame1 first", 32'(words[base]), HDR ? 32'h0000A500 : 32'h00000100);
    chk("frame1 last", 32'(words[words.size() - 1]), 32'h0108);
    chk("frame1 count", 32'(bus.frame_count), 32'd1);
    sel_release();

    // FIFO 3 empty
    load_fifos(1);
    sel_fall();
    base = words.size();
    for (int i = 0; i < NUM_MICS + HDR; i++) issue_req(3);
    repeat (8) @(posedge clk);
    check_static();
    chk("fill word", 32'(words[base + HDR + 3]), 32'h0007);
    chk("underrun", 32'(bus.underrun_count), 32'd1);
    chk("frame2 count", 32'(bus.frame_count), 32'd2);
    sel_release();

    // overrun: second request inside the busy window
    load_fifos(0);
    sel_fall();
    nv0 = n_valid;
    issue_req(2);
    issue_req(6);
    repeat (4) @(posedge clk);
    check_static();
    chk("overrun words", 32'(n_valid - nv0), 32'd1);
    chk("overrun set", 32'(bus.overrun_err), 32'd1);
    sel_release();
    sel_fall();
    chk("overrun cleared", 32'(bus.overrun_err), 32'd0);

    // abort: ssel released one clock after the request edge
    issue_req(4);
    issue_req(4);
    nv0 = n_valid;
    @(posedge clk); #1;
    bus.data_needed = 1'b1;
    model_req(cyc);
    @(posedge clk); #1;
    bus.data_needed = 1'b0;
    bus.ssel = 1'b1;
    model_sel_rise(cyc);
    repeat (8) @(posedge clk);
    check_static();
    chk("abort words", 32'(n_valid - nv0 - 1), 32'd0);
    chk("abort mic_idx", 32'(bus.mic_idx), 32'(2 - HDR));

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int nreq = $urandom_range(4, 24);
      load_fifos(2);
      sel_fall();
      for (int r = 0; r < nreq; r++)
        issue_req(($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(3, 6)));
      repeat (8) @(posedge clk);
      check_static();
      sel_release();
      check_static();
    end

    // reset asserted during READ
    load_fifos(0);
    sel_fall();
    @(posedge clk); #1;
    bus.data_needed = 1'b1;
    @(posedge clk); #1;
    bus.data_needed = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ssel = 1'b1;
    eq.delete();
    m_armed = 0; m_idx = 0; m_fc = 0; m_ur = 0; m_ovr = 0; m_hdr = (HDR != 0); last_r = -100;
    @(posedge clk);
    @(negedge clk);
    chk("rst tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst tx_data", 32'(bus.tx_data), 32'h0007);
    chk("rst rdreq", 32'(bus.fifo_rdreq), 32'd0);
    chk("rst rdclk_en", 32'(bus.fifo_rdclk_en), 32'd0);
    check_static();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    check_static();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
